// File: rtl/game_seq_ctrl_pkg.sv
// rtl/game_seq_ctrl_pkg.sv - shared STATE bus encodings and helpers for the game sequencer
package game_seq_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'b0001,
        ST_READY    = 4'b0010,
        ST_QUESTION = 4'b0011,
        ST_INPUT    = 4'b0100,
        ST_JUDGE    = 4'b0101,
        ST_CORRECT  = 4'b0110,
        ST_WRONG    = 4'b0111,
        ST_CLEAR    = 4'b1000,
        ST_TIMEOUT  = 4'b1001,
        ST_GAMEOVER = 4'b1010,
        ST_RESULT   = 4'b1011
    } state_t;

    localparam int STATE_W = 4;
    localparam int QNUM_W  = 3;
    localparam int MISS_W  = 2;
    localparam int TIME_W  = 6;

    // True in the end-of-game states where the display shows the final score.
    function automatic logic is_game_end(input state_t s);
        return (s == ST_CLEAR) || (s == ST_GAMEOVER) || (s == ST_RESULT);
    endfunction

    // True in states that hold for a fixed number of seconds and then move on.
    function automatic logic is_show_state(input state_t s);
        return (s == ST_QUESTION) || (s == ST_CORRECT) || (s == ST_WRONG) ||
               (s == ST_TIMEOUT)  || (s == ST_CLEAR)   || (s == ST_GAMEOVER);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - one-second tick prescaler, restartable by CLR
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam int                CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign TICK = (cnt_q == LAST);

    // Count 0..TICK_DIV-1; CLR restarts the second so every state window starts aligned.
    always_ff @(posedge CLK) begin
        if (RST || CLR || TICK) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/game_seq_ctrl.sv
// rtl/game_seq_ctrl.sv - master game sequencer driving the STATE bus
module game_seq_ctrl
    import game_seq_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int Q_TIME   = 30,
    parameter int SHOW_SEC = 2,
    parameter int NUM_Q    = 5,
    parameter int MAX_MISS = 3,
    parameter int JUDGE_TO = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                DEC,
    input  logic                QUE_OK,
    input  logic                JUDGE_VALID,
    input  logic                JUDGE_OK,
    output logic [STATE_W-1:0]  STATE,
    output logic                Q_REQ,
    output logic [QNUM_W-1:0]   Q_NUM,
    output logic [MISS_W-1:0]   MISS,
    output logic [TIME_W-1:0]   TIME_LEFT,
    output logic                GAME_END
);

    localparam int SEC_W = $clog2(SHOW_SEC + 1);
    localparam int JDG_W = $clog2(JUDGE_TO + 1);

    localparam logic [SEC_W-1:0]  SHOW_LAST  = SEC_W'(SHOW_SEC - 1);
    localparam logic [JDG_W-1:0]  JUDGE_LAST = JDG_W'(JUDGE_TO - 1);
    localparam logic [QNUM_W-1:0] Q_LAST     = QNUM_W'(NUM_Q - 1);
    localparam logic [QNUM_W-1:0] Q_SAT      = '1;
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);
    localparam logic [MISS_W-1:0] MISS_SAT   = '1;
    localparam logic [TIME_W-1:0] TIME_LOAD  = TIME_W'(Q_TIME);

    state_t             state_q;
    state_t             state_d;
    logic               state_chg;

    logic               start_prev;
    logic               dec_prev;
    logic               start_edge;
    logic               dec_edge;

    logic               tick;
    logic [SEC_W-1:0]   sec_cnt_q;
    logic [JDG_W-1:0]   jdg_cnt_q;
    logic               show_done;
    logic               judge_expired;

    logic [QNUM_W-1:0]  q_num_q;
    logic [MISS_W-1:0]  miss_q;
    logic [TIME_W-1:0]  time_left_q;
    logic               q_req_q;
    logic               last_q;
    logic               miss_full;
    logic               game_end;

    assign start_edge    = START & ~start_prev;
    assign dec_edge      = DEC & ~dec_prev;
    assign state_chg     = (state_d != state_q);
    assign show_done     = tick && (sec_cnt_q == SHOW_LAST) && is_show_state(state_q);
    assign judge_expired = (jdg_cnt_q == JUDGE_LAST);
    assign last_q        = (q_num_q == Q_LAST);
    assign miss_full     = (miss_q == MISS_LIMIT);

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (state_chg),
        .TICK (tick)
    );

    // Button edge detectors; preset high so a button held through reset gives no edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_prev <= 1'b1;
            dec_prev   <= 1'b1;
        end else begin
            start_prev <= START;
            dec_prev   <= DEC;
        end
    end

    // Per-state elapsed counters: seconds for display windows, cycles for the judge wait.
    always_ff @(posedge CLK) begin
        if (RST || state_chg) begin
            sec_cnt_q <= '0;
            jdg_cnt_q <= '0;
        end else begin
            if (tick) begin
                sec_cnt_q <= sec_cnt_q + SEC_W'(1);
            end
            if (!judge_expired) begin
                jdg_cnt_q <= jdg_cnt_q + JDG_W'(1);
            end
        end
    end

    // State register; illegal encodings are caught by the next-state default.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_TITLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and combinational outputs.
    always_comb begin
        state_d  = state_q;
        game_end = is_game_end(state_q);
        case (state_q)
            ST_TITLE: begin
                if (start_edge) state_d = ST_READY;
            end
            ST_READY: begin
                if (QUE_OK) state_d = ST_QUESTION;
            end
            ST_QUESTION: begin
                if (show_done) state_d = ST_INPUT;
            end
            ST_INPUT: begin
                // A decide press in the expiry cycle still gets judged.
                if (dec_edge) begin
                    state_d = ST_JUDGE;
                end else if (tick && (time_left_q <= TIME_W'(1))) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_JUDGE: begin
                if (JUDGE_VALID) begin
                    state_d = JUDGE_OK ? ST_CORRECT : ST_WRONG;
                end else if (judge_expired) begin
                    state_d = ST_WRONG;
                end
            end
            ST_CORRECT: begin
                if (show_done) state_d = last_q ? ST_CLEAR : ST_READY;
            end
            ST_WRONG: begin
                if (show_done) state_d = miss_full ? ST_GAMEOVER : ST_INPUT;
            end
            ST_TIMEOUT: begin
                if (show_done) begin
                    if (miss_full)   state_d = ST_GAMEOVER;
                    else if (last_q) state_d = ST_CLEAR;
                    else             state_d = ST_READY;
                end
            end
            ST_CLEAR, ST_GAMEOVER: begin
                if (show_done) state_d = ST_RESULT;
            end
            ST_RESULT: begin
                if (start_edge) state_d = ST_TITLE;
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase
    end

    // Game counters and the question-request pulse, all updated on state transitions.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_num_q     <= '0;
            miss_q      <= '0;
            time_left_q <= '0;
            q_req_q     <= 1'b0;
        end else begin
            q_req_q <= (state_d == ST_READY) && (state_q != ST_READY);

            if ((state_q == ST_TITLE) && (state_d == ST_READY)) begin
                q_num_q <= '0;
            end else if (((state_q == ST_CORRECT) || (state_q == ST_TIMEOUT)) &&
                         (state_d == ST_READY) && (q_num_q != Q_SAT)) begin
                q_num_q <= q_num_q + QNUM_W'(1);
            end

            if ((state_q == ST_TITLE) && (state_d == ST_READY)) begin
                miss_q <= '0;
            end else if (state_chg && ((state_d == ST_WRONG) || (state_d == ST_TIMEOUT)) &&
                         (miss_q != MISS_SAT)) begin
                miss_q <= miss_q + MISS_W'(1);
            end

            // The timer freezes outside INPUT, so a wrong-answer retry resumes where it was.
            if ((state_q == ST_READY) && (state_d == ST_QUESTION)) begin
                time_left_q <= TIME_LOAD;
            end else if ((state_q == ST_INPUT) && tick && (time_left_q != '0)) begin
                time_left_q <= time_left_q - TIME_W'(1);
            end
        end
    end

    assign STATE     = state_q;
    assign Q_REQ     = q_req_q;
    assign Q_NUM     = q_num_q;
    assign MISS      = miss_q;
    assign TIME_LEFT = time_left_q;
    assign GAME_END  = game_end;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// tb/tb_game_seq_ctrl.sv - self-checking bench for game_seq_ctrl
module tb_game_seq_ctrl;

    localparam int TD  = 4;
    localparam int QT  = 3;
    localparam int SS  = 1;
    localparam int NQ  = 2;
    localparam int MM  = 2;
    localparam int JTO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dec;
    logic       que_ok;
    logic       judge_valid;
    logic       judge_ok;
    logic [3:0] state;
    logic       q_req;
    logic [2:0] q_num;
    logic [1:0] miss;
    logic [5:0] time_left;
    logic       game_end;

    int n_chk  = 0;
    int n_fail = 0;

    int m_state, m_t, m_q, m_miss, m_tl;
    bit m_qreq, m_ps, m_pd;

    game_seq_ctrl #(
        .TICK_DIV (TD),
        .Q_TIME   (QT),
        .SHOW_SEC (SS),
        .NUM_Q    (NQ),
        .MAX_MISS (MM),
        .JUDGE_TO (JTO)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .START       (start),
        .DEC         (dec),
        .QUE_OK      (que_ok),
        .JUDGE_VALID (judge_valid),
        .JUDGE_OK    (judge_ok),
        .STATE       (state),
        .Q_REQ       (q_req),
        .Q_NUM       (q_num),
        .MISS        (miss),
        .TIME_LEFT   (time_left),
        .GAME_END    (game_end)
    );

    always #5 clk = ~clk;

    // Reference: rules applied to elapsed cycles in the current state.
    task automatic model_step();
        int ns;
        bit se, de, tk, shown;
        if (rst) begin
            m_state = 1; m_t = 0; m_q = 0; m_miss = 0; m_tl = 0; m_qreq = 0; m_ps = 1; m_pd = 1;
            return;
        end
        se = start && !m_ps;
        de = dec && !m_pd;
        m_ps = start;
        m_pd = dec;
        tk = ((m_t + 1) % TD) == 0;
        shown = (m_t + 1) == SS * TD;
        ns = m_state;
        case (m_state)
            1: if (se) begin ns = 2; m_q = 0; m_miss = 0; end
            2: if (que_ok) begin ns = 3; m_tl = QT; end
            3: if (shown) ns = 4;
            4: begin
                if (de) ns = 5;
                else if (tk && m_tl <= 1) ns = 9;
                if (tk && m_tl > 0) m_tl = m_tl - 1;
            end
            5: if (judge_valid) ns = judge_ok ? 6 : 7; else if (m_t + 1 == JTO) ns = 7;
            6: if (shown) begin if (m_q == NQ - 1) ns = 8; else begin ns = 2; m_q = m_q + 1; end end
            7: if (shown) ns = (m_miss == MM) ? 10 : 4;
            9: if (shown) begin
                if (m_miss == MM) ns = 10;
                else if (m_q == NQ - 1) ns = 8;
                else begin ns = 2; m_q = m_q + 1; end
            end
            8, 10: if (shown) ns = 11;
            11: if (se) ns = 1;
            default: ns = 1;
        endcase
        m_qreq = (ns == 2) && (m_state != 2);
        if ((ns == 7 || ns == 9) && ns != m_state) m_miss = (m_miss < 3) ? m_miss + 1 : 3;
        m_t = (ns == m_state) ? m_t + 1 : 0;
        m_state = ns;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic press_start();
        start = 1'b0; cycle();
        start = 1'b1; cycle();
        start = 1'b0;
    endtask

    task automatic press_dec();
        dec = 1'b1; cycle();
        dec = 1'b0;
    endtask

    task automatic enter_question();
        que_ok = 1'b1; cycle();
        que_ok = 1'b0;
    endtask

    task automatic judge(input bit ok);
        judge_valid = 1'b1; judge_ok = ok; cycle();
        judge_valid = 1'b0; judge_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(2); rst = 1'b0; cycle();
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL reset_state: got %0d want 1", state); end
        n_chk++; if (q_req !== 1'b0) begin n_fail++; $display("FAIL reset_qreq: got %0d want 0", q_req); end
        n_chk++; if (q_num !== 3'd0) begin n_fail++; $display("FAIL reset_qnum: got %0d want 0", q_num); end
        n_chk++; if (miss !== 2'd0) begin n_fail++; $display("FAIL reset_miss: got %0d want 0", miss); end
        n_chk++; if (time_left !== 6'd0) begin n_fail++; $display("FAIL reset_time: got %0d want 0", time_left); end
        n_chk++; if (game_end !== 1'b0) begin n_fail++; $display("FAIL reset_gend: got %0d want 0", game_end); end
    endtask

    task automatic test_start();
        press_start();
        n_chk++; if (state !== 4'd2) begin n_fail++; $display("FAIL start_ready: got %0d want 2", state); end
        n_chk++; if (q_req !== 1'b1) begin n_fail++; $display("FAIL start_qreq: got %0d want 1", q_req); end
        cycle();
        n_chk++; if (q_req !== 1'b0) begin n_fail++; $display("FAIL qreq_single: got %0d want 0", q_req); end
        n_chk++; if (state !== 4'd2) begin n_fail++; $display("FAIL ready_wait: got %0d want 2", state); end
        enter_question();
        n_chk++; if (state !== 4'd3) begin n_fail++; $display("FAIL question: got %0d want 3", state); end
        n_chk++; if (time_left !== 6'd3) begin n_fail++; $display("FAIL time_load: got %0d want 3", time_left); end
        idle(3);
        n_chk++; if (state !== 4'd3) begin n_fail++; $display("FAIL question_hold: got %0d want 3", state); end
        cycle();
        n_chk++; if (state !== 4'd4) begin n_fail++; $display("FAIL input: got %0d want 4", state); end
    endtask

    task automatic test_clear();
        press_dec();
        n_chk++; if (state !== 4'd5) begin n_fail++; $display("FAIL judge: got %0d want 5", state); end
        judge(1'b1);
        n_chk++; if (state !== 4'd6) begin n_fail++; $display("FAIL correct: got %0d want 6", state); end
        idle(4);
        n_chk++; if (state !== 4'd2) begin n_fail++; $display("FAIL next_ready: got %0d want 2", state); end
        n_chk++; if (q_num !== 3'd1) begin n_fail++; $display("FAIL qnum_inc: got %0d want 1", q_num); end
        enter_question(); idle(4); press_dec(); judge(1'b1); idle(4);
        n_chk++; if (state !== 4'd8) begin n_fail++; $display("FAIL clear: got %0d want 8", state); end
        n_chk++; if (game_end !== 1'b1) begin n_fail++; $display("FAIL clear_gend: got %0d want 1", game_end); end
        idle(4);
        n_chk++; if (state !== 4'd11) begin n_fail++; $display("FAIL result: got %0d want 11", state); end
        n_chk++; if (q_num !== 3'd1) begin n_fail++; $display("FAIL result_qnum: got %0d want 1", q_num); end
        press_start();
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL back_title: got %0d want 1", state); end
    endtask

    task automatic test_wrong();
        press_start(); enter_question(); idle(4); idle(2); press_dec(); judge(1'b0);
        n_chk++; if (state !== 4'd7) begin n_fail++; $display("FAIL wrong: got %0d want 7", state); end
        n_chk++; if (miss !== 2'd1) begin n_fail++; $display("FAIL wrong_miss: got %0d want 1", miss); end
        idle(4);
        n_chk++; if (state !== 4'd4) begin n_fail++; $display("FAIL retry: got %0d want 4", state); end
        n_chk++; if (time_left !== 6'd3) begin n_fail++; $display("FAIL retry_time: got %0d want 3", time_left); end
        press_dec(); judge(1'b0); idle(4);
        n_chk++; if (state !== 4'd10) begin n_fail++; $display("FAIL gameover: got %0d want 10", state); end
        idle(4);
        n_chk++; if (state !== 4'd11) begin n_fail++; $display("FAIL go_result: got %0d want 11", state); end
        n_chk++; if (miss !== 2'd2) begin n_fail++; $display("FAIL result_miss: got %0d want 2", miss); end
        press_start();
    endtask

    task automatic test_timeout();
        press_start();
        n_chk++; if (miss !== 2'd0) begin n_fail++; $display("FAIL miss_clear: got %0d want 0", miss); end
        enter_question(); idle(4);
        for (int k = 2; k >= 1; k--) begin
            idle(4);
            n_chk++; if (time_left !== 6'(k)) begin n_fail++; $display("FAIL time_step: got %0d want %0d", time_left, k); end
        end
        idle(4);
        n_chk++; if (state !== 4'd9) begin n_fail++; $display("FAIL timeout: got %0d want 9", state); end
        n_chk++; if (time_left !== 6'd0) begin n_fail++; $display("FAIL time_zero: got %0d want 0", time_left); end
        n_chk++; if (miss !== 2'd1) begin n_fail++; $display("FAIL timeout_miss: got %0d want 1", miss); end
        idle(4);
        n_chk++; if (state !== 4'd2) begin n_fail++; $display("FAIL to_ready: got %0d want 2", state); end
        n_chk++; if (q_num !== 3'd1) begin n_fail++; $display("FAIL to_qnum: got %0d want 1", q_num); end
        enter_question(); idle(4); idle(8); idle(3);
        press_dec();
        n_chk++; if (state !== 4'd5) begin n_fail++; $display("FAIL dec_wins: got %0d want 5", state); end
        judge(1'b1); idle(8); press_start();
    endtask

    task automatic test_judge_timeout();
        press_start(); enter_question(); idle(4); press_dec(); idle(15);
        n_chk++; if (state !== 4'd5) begin n_fail++; $display("FAIL judge_wait: got %0d want 5", state); end
        cycle();
        n_chk++; if (state !== 4'd7) begin n_fail++; $display("FAIL judge_to: got %0d want 7", state); end
    endtask

    task automatic test_start_thru_reset();
        start = 1'b1; rst = 1'b1; idle(2); rst = 1'b0; idle(2);
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL held_start: got %0d want 1", state); end
        start = 1'b0; cycle();
    endtask

    task automatic test_reset_mid();
        press_start(); enter_question(); idle(4); idle(12); idle(4); enter_question(); idle(8);
        n_chk++; if (time_left !== 6'd2) begin n_fail++; $display("FAIL pre_rst_time: got %0d want 2", time_left); end
        rst = 1'b1; cycle(); rst = 1'b0;
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL mid_rst_state: got %0d want 1", state); end
        n_chk++; if ({q_num, miss, time_left} !== 11'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0h want 0", {q_num, miss, time_left}); end
    endtask

    task automatic test_illegal();
        force dut.state_q = game_seq_ctrl_pkg::state_t'(4'b1100);
        #1;
        release dut.state_q;
        @(posedge clk); #1;
        n_chk++; if (state !== 4'd1) begin n_fail++; $display("FAIL illegal: got %0d want 1", state); end
    endtask

    task automatic test_random();
        bit ge;
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 399) == 0);
            start       = $urandom_range(0, 1);
            dec         = $urandom_range(0, 1);
            que_ok      = ($urandom_range(0, 2) == 0);
            judge_valid = ($urandom_range(0, 3) == 0);
            judge_ok    = $urandom_range(0, 1);
            cycle();
            ge = (m_state == 8) || (m_state == 10) || (m_state == 11);
            n_chk++; if (state !== 4'(m_state)) begin n_fail++; $display("FAIL rnd_state: cyc %0d got %0d want %0d", i, state, m_state); end
            n_chk++; if (q_num !== 3'(m_q)) begin n_fail++; $display("FAIL rnd_qnum: cyc %0d got %0d want %0d", i, q_num, m_q); end
            n_chk++; if (miss !== 2'(m_miss)) begin n_fail++; $display("FAIL rnd_miss: cyc %0d got %0d want %0d", i, miss, m_miss); end
            n_chk++; if (time_left !== 6'(m_tl)) begin n_fail++; $display("FAIL rnd_time: cyc %0d got %0d want %0d", i, time_left, m_tl); end
            n_chk++; if (q_req !== m_qreq) begin n_fail++; $display("FAIL rnd_qreq: cyc %0d got %0d want %0d", i, q_req, m_qreq); end
            n_chk++; if (game_end !== ge) begin n_fail++; $display("FAIL rnd_gend: cyc %0d got %0d want %0d", i, game_end, ge); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dec = 1'b0; que_ok = 1'b0; judge_valid = 1'b0; judge_ok = 1'b0;
        m_state = 1; m_t = 0; m_q = 0; m_miss = 0; m_tl = 0; m_qreq = 0; m_ps = 1; m_pd = 1;
        test_reset();
        test_start();
        test_clear();
        test_wrong();
        test_timeout();
        test_judge_timeout();
        test_start_thru_reset();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
